// File: rtl/pipeline_debug_pkg.sv
// Shared types and constants for the pipeline debug sequencer.
// Frame layout offsets are in bytes from the header byte.
package pipeline_debug_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        SNAP,
        DUMP
    } state_t;

    localparam logic [7:0] OP_RUN   = 8'h52;
    localparam logic [7:0] OP_PAUSE = 8'h50;
    localparam logic [7:0] OP_STEP  = 8'h53;
    localparam logic [7:0] OP_DUMP  = 8'h44;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int FRAME_BYTES = 175;
    localparam int FRAME_BITS  = FRAME_BYTES * 8;
    localparam int IDX_W       = 8;

    localparam int OFF_HDR   = 0;
    localparam int OFF_CNT   = 1;
    localparam int OFF_PC    = 3;
    localparam int OFF_INSTR = 4;
    localparam int OFF_IFID  = 8;
    localparam int OFF_IDEX  = 13;
    localparam int OFF_EXM   = 29;
    localparam int OFF_MWB   = 38;
    localparam int OFF_REGS  = 47;

endpackage

// File: rtl/pipeline_debug_ctrl_snapshot_serializer.sv
// Holds a captured frame image and streams it byte by byte
// over a valid/ready link; done pulses on the last handshake.
module snapshot_serializer
    import pipeline_debug_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    output logic                  done,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    logic [FRAME_BITS-1:0] snap_q;
    logic [IDX_W-1:0]      idx;
    logic                  fire;

    assign fire     = busy & tx_ready;
    assign done     = fire & (idx == LAST_IDX);
    assign tx_valid = busy;
    assign tx_data  = busy ? snap_q[idx*8 +: 8] : 8'h00;

    // Frame image is frozen at capture; live inputs cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q <= '0;
        end else if (capture) begin
            snap_q <= frame;
        end
    end

    // Byte index advances only when the sink takes the current byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            idx  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            idx  <= '0;
        end else if (done) begin
            busy <= 1'b0;
            idx  <= '0;
        end else if (fire) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Debug sequencer: run/pause/step control, HALT detect,
// cycle counting and snapshot frame dump to the host link.
module pipeline_debug_ctrl
    import pipeline_debug_pkg::*;
#(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 16,
    parameter bit          AUTO_DUMP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_data,
    output logic             cmd_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             pipe_enable,
    input  logic [6:0]       pc,
    input  logic [31:0]      instruccion,
    input  logic [38:0]      if_id,
    input  logic [126:0]     id_ex,
    input  logic [71:0]      ex_m,
    input  logic [70:0]      m_wb,
    input  logic [1023:0]    registros,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    state_t state, state_nxt;
    logic   cmd_fire, halt_hit, capture, ser_busy, ser_done;
    logic   [FRAME_BITS-1:0] frame;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign halt_hit = pipe_enable & (instruccion == HALT_WORD);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; HALT outranks a same-cycle pause.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_data == OP_RUN)       state_nxt = RUN;
                    else if (cmd_data == OP_STEP) state_nxt = STEP;
                    else if (cmd_data == OP_DUMP) state_nxt = SNAP;
                end
            end
            RUN: begin
                if (halt_hit)
                    state_nxt = AUTO_DUMP ? SNAP : IDLE;
                else if (cmd_fire && cmd_data == OP_PAUSE)
                    state_nxt = IDLE;
            end
            STEP:    state_nxt = AUTO_DUMP ? SNAP : IDLE;
            SNAP:    state_nxt = DUMP;
            DUMP:    if (ser_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        pipe_enable = (state == RUN) || (state == STEP);
        cmd_ready   = (state == IDLE) || (state == RUN);
        capture     = (state == SNAP);
    end

    // Halted is sticky until the host resumes with run or step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (halt_hit) begin
            halted <= 1'b1;
        end else if (state == IDLE && cmd_fire &&
                     (cmd_data == OP_RUN || cmd_data == OP_STEP)) begin
            halted <= 1'b0;
        end
    end

    // Enabled-cycle counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             cycle_count <= '0;
        else if (pipe_enable) cycle_count <= cycle_count + 1'b1;
    end

    // Frame image: each field little-endian, zero-padded to bytes.
    always_comb begin
        frame = '0;
        frame[OFF_HDR*8   +: 8]    = FRAME_HDR;
        frame[OFF_CNT*8   +: 16]   = 16'(cycle_count);
        frame[OFF_PC*8    +: 7]    = pc;
        frame[OFF_INSTR*8 +: 32]   = instruccion;
        frame[OFF_IFID*8  +: 39]   = if_id;
        frame[OFF_IDEX*8  +: 127]  = id_ex;
        frame[OFF_EXM*8   +: 72]   = ex_m;
        frame[OFF_MWB*8   +: 71]   = m_wb;
        frame[OFF_REGS*8  +: 1024] = registros;
    end

    snapshot_serializer u_ser (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .start    (capture),
        .frame    (frame),
        .busy     (ser_busy),
        .done     (ser_done),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed-plus-random bench for pipeline_debug_ctrl; expected
// frames are assembled field by field from the input images.
module tb_pipeline_debug_ctrl;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [7:0]    cmd_data = 8'h00;
    logic          tx_ready = 1'b0;
    logic [6:0]    pc = '0;
    logic [31:0]   instruccion = '0;
    logic [38:0]   if_id = '0;
    logic [126:0]  id_ex = '0;
    logic [71:0]   ex_m = '0;
    logic [70:0]   m_wb = '0;
    logic [1023:0] registros = '0;

    logic          cmd_ready, tx_valid, pipe_enable, halted;
    logic [7:0]    tx_data;
    logic [15:0]   cycle_count;
    logic          cmd_ready4, tx_valid4, pipe_enable4, halted4;
    logic [7:0]    tx_data4;
    logic [3:0]    cycle_count4;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pipeline_debug_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .pipe_enable(pipe_enable), .pc(pc),
        .instruccion(instruccion), .if_id(if_id), .id_ex(id_ex),
        .ex_m(ex_m), .m_wb(m_wb), .registros(registros),
        .halted(halted), .cycle_count(cycle_count)
    );

    pipeline_debug_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready4), .tx_valid(tx_valid4), .tx_data(tx_data4),
        .tx_ready(tx_ready), .pipe_enable(pipe_enable4), .pc(pc),
        .instruccion(instruccion), .if_id(if_id), .id_ex(id_ex),
        .ex_m(ex_m), .m_wb(m_wb), .registros(registros),
        .halted(halted4), .cycle_count(cycle_count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_inputs();
        pc          = 7'($urandom);
        instruccion = $urandom & 32'h7FFF_FFFF;
        if_id       = 39'({$urandom, $urandom});
        id_ex       = 127'({$urandom, $urandom, $urandom, $urandom});
        ex_m        = 72'({$urandom, $urandom, $urandom});
        m_wb        = 71'({$urandom, $urandom, $urandom});
        for (int i = 0; i < 32; i++) registros[i*32 +: 32] = $urandom;
    endtask

    task automatic push_field(input logic [1023:0] v, input int nbytes);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic build_exp(input logic [15:0] cnt);
        exp_q.delete();
        push_field(1024'(8'hA5), 1);
        push_field(1024'(cnt), 2);
        push_field(1024'(pc), 1);
        push_field(1024'(instruccion), 4);
        push_field(1024'(if_id), 5);
        push_field(1024'(id_ex), 16);
        push_field(1024'(ex_m), 9);
        push_field(1024'(m_wb), 9);
        push_field(registros, 128);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send_cmd(input logic [7:0] op);
        int n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_wait", 64'(n < 3000), 1);
        cmd_valid = 1'b1;
        cmd_data  = op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // mode 0: tx_ready toggles; mode 1: random ready and input churn.
    task automatic recv(input int mode, input int stop_at);
        int cyc = 0;
        int bad_stable = 0;
        int bad_ready = 0;
        logic tog = 1'b1;
        logic r, pv, pr;
        logic [7:0] pd;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        rx_q.delete();
        while (rx_q.size() < stop_at && cyc < 3000) begin
            if (pv && !pr && (!tx_valid || tx_data !== pd)) bad_stable++;
            if (tx_valid && cmd_ready) bad_ready++;
            r = (mode == 0) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            tx_ready = r;
            if (mode == 1 && tx_valid) rand_inputs();
            if (tx_valid && r) rx_q.push_back(tx_data);
            pv = tx_valid; pr = r; pd = tx_data;
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        chk("rx_timeout", 64'(rx_q.size() >= stop_at), 1);
        chk("tx_stable", 64'(bad_stable), 0);
        chk("cmd_ready_in_dump", 64'(bad_ready), 0);
    endtask

    task automatic cmp_frame(input string tag);
        int nbad = 0;
        int first = -1;
        chk({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        chk({tag, "_bytes"}, 64'(nbad), 0);
        if (first >= 0) chk({tag, "_first_bad"}, 64'(rx_q[first]), 64'(exp_q[first]));
    endtask

    initial begin
        int nreg;
        logic [7:0] b0, b1, b2;

        // Reset values
        rand_inputs();
        repeat (2) @(negedge clk);
        chk("rst_pipe_enable", 64'(pipe_enable), 0);
        chk("rst_tx_valid", 64'(tx_valid), 0);
        chk("rst_tx_data", 64'(tx_data), 0);
        chk("rst_halted", 64'(halted), 0);
        chk("rst_cycle_count", 64'(cycle_count), 0);
        chk("rst_cmd_ready", 64'(cmd_ready), 1);
        rst = 1'b1;
        @(negedge clk);

        // 1: dump with toggling tx_ready
        build_exp(16'd0);
        send_cmd(8'h44);
        recv(0, 175);
        b0 = rx_q[0]; b1 = rx_q[1]; b2 = rx_q[2];
        chk("t1_hdr", 64'(b0), 64'h A5);
        chk("t1_cnt_lo", 64'(b1), 0);
        chk("t1_cnt_hi", 64'(b2), 0);
        nreg = 0;
        for (int i = 47; i < 175 && i < rx_q.size(); i++)
            if (rx_q[i] !== registros[(i-47)*8 +: 8]) nreg++;
        chk("t1_regs", 64'(nreg), 0);
        cmp_frame("t1_frame");

        // 2: three single steps
        for (int k = 1; k <= 3; k++) begin
            rand_inputs();
            build_exp(16'(k));
            send_cmd(8'h53);
            chk("t2_en_step", 64'(pipe_enable), 1);
            @(negedge clk);
            chk("t2_en_after", 64'(pipe_enable), 0);
            recv(1, 175);
            cmp_frame("t2_frame");
            chk("t2_halted", 64'(halted), 0);
        end

        // 3: run into HALT at pc=10
        do_reset();
        rand_inputs();
        send_cmd(8'h52);
        for (int k = 0; k <= 10; k++) begin
            pc = 7'(k);
            instruccion = (k == 10) ? 32'hFFFF_FFFF
                                    : ($urandom & 32'h7FFF_FFFF);
            chk("t3_en_run", 64'(pipe_enable), 1);
            @(negedge clk);
        end
        chk("t3_en_drop", 64'(pipe_enable), 0);
        chk("t3_halted", 64'(halted), 1);
        build_exp(16'd11);
        recv(1, 175);
        cmp_frame("t3_frame");
        chk("t3_pc_byte", 64'(rx_q[3]), 64'd10);
        chk("t3_instr", 64'({rx_q[7], rx_q[6], rx_q[5], rx_q[4]}),
            64'hFFFF_FFFF);
        rand_inputs();
        build_exp(16'd12);
        send_cmd(8'h53);
        chk("t3_halt_clr", 64'(halted), 0);
        recv(1, 175);
        cmp_frame("t3_step_frame");

        // 4: run 20 cycles then pause
        do_reset();
        rand_inputs();
        send_cmd(8'h52);
        repeat (19) @(negedge clk);
        send_cmd(8'h50);
        chk("t4_en_off", 64'(pipe_enable), 0);
        chk("t4_count", 64'(cycle_count), 64'd20);
        rand_inputs();
        build_exp(16'h0014);
        send_cmd(8'h44);
        recv(1, 175);
        cmp_frame("t4_frame");

        // 5: reset in the middle of a dump
        do_reset();
        rand_inputs();
        send_cmd(8'h44);
        recv(1, 50);
        chk("t5_mid_valid", 64'(tx_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(tx_valid), 0);
        chk("t5_rst_data", 64'(tx_data), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rand_inputs();
        build_exp(16'd0);
        send_cmd(8'h44);
        recv(1, 175);
        cmp_frame("t5_frame");

        // 6: unknown opcode, then 17 steps on the narrow counter
        do_reset();
        send_cmd(8'h00);
        chk("t6_unk_en", 64'(pipe_enable), 0);
        chk("t6_unk_ready", 64'(cmd_ready), 1);
        @(negedge clk);
        chk("t6_unk_tx", 64'(tx_valid), 0);
        chk("t6_unk_cnt", 64'(cycle_count), 0);
        for (int k = 1; k <= 17; k++) begin
            rand_inputs();
            build_exp(16'(k));
            send_cmd(8'h53);
            recv(1, 175);
            cmp_frame("t6_frame");
        end
        chk("t6_count16", 64'(cycle_count), 64'd17);
        chk("t6_count4", 64'(cycle_count4), 64'(17 % 16));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
